// File: rtl/alu_74181_seq.sv
// -----------------------------------------------------------------------------
// alu_74181_seq
// Slice-serial 74181-style ALU. A single 4-bit 74181-equivalent slice is
// reused over WIDTH/4 cycles, LSB slice first. The ripple carry and the
// word-level propagate/generate terms are carried in registers between slices.
// A start/busy/done handshake frames each operation.
//
// Optional feature macro: ALU_SEQ_ACCUM_EN
//   When defined, the 'acc' input exists. On an accepted start with acc=1,
//   operand A is taken from the current result f instead of from 'a'.
//
// Parameters:
//   WIDTH  operand width; must be a multiple of 4 and at least 4
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled when not busy (IDLE or DONE)
//   a, b   in   WIDTH-bit operands, latched on an accepted start
//   s      in   4-bit 74181 function select, latched on start
//   m      in   1 = logic mode, 0 = arithmetic, latched on start
//   cn     in   carry in, active-low carry (1 = no carry), latched on start
//   acc    in   (ALU_SEQ_ACCUM_EN only) take operand A from previous f
//   busy   out  high while slices are being evaluated
//   done   out  one-cycle pulse, results valid from this cycle
//   f      out  WIDTH-bit result
//   cout   out  carry out of the last slice, active-low
//   equal  out  AND of all slice A=B outputs (f all ones)
//   p_n    out  word-level propagate, active-low
//   g_n    out  word-level generate, active-low
// -----------------------------------------------------------------------------
module alu_74181_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
`ifdef ALU_SEQ_ACCUM_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             equal,
    output logic             p_n,
    output logic             g_n
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("alu_74181_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One 74181 slice with active-high data.
    // Returns {cn4 (active-low carry), A=B, group P (active-high),
    //          group G (active-high), F[3:0]}.
    function automatic logic [7:0] slice_181(
        input logic [3:0] sa,
        input logic [3:0] sb,
        input logic [3:0] sel,
        input logic       sm,
        input logic       scn
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] fo;
        logic [4:0] c;
        logic       gp;
        logic       gg;
        c[0] = ~scn;
        for (int i = 0; i < 4; i++) begin
            p[i]     = sa[i] | (sb[i] & sel[0]) | (~sb[i] & sel[1]);
            g[i]     = (sa[i] & ~sb[i] & sel[2]) | (sa[i] & sb[i] & sel[3]);
            c[i+1]   = g[i] | (p[i] & c[i]);
            // g implies p, so p&~g is the half-sum; logic mode forces the
            // carry term high, which inverts it to the logic function.
            fo[i]    = (p[i] & ~g[i]) ^ (sm | c[i]);
        end
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {~c[4], &fo, gp, gg, fo};
    endfunction

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_s;
    logic              r_m;
    logic              r_carry;
    logic              r_pp;
    logic              r_gg;
    logic              r_eq;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_f;
    logic              r_cout;
    logic              r_equal;
    logic              r_p_n;
    logic              r_g_n;

    logic [7:0]        w_slice;
    logic              w_cn4;
    logic              w_aeqb;
    logic              w_p;
    logic              w_g;
    logic [3:0]        w_f;
    logic [WIDTH-1:0]  w_a_src;

    // Operands are shifted right one nibble per slice, so the slice always
    // reads the low nibble.
    assign w_slice = slice_181(r_a[3:0], r_b[3:0], r_s, r_m, r_carry);
    assign w_cn4   = w_slice[7];
    assign w_aeqb  = w_slice[6];
    assign w_p     = w_slice[5];
    assign w_g     = w_slice[4];
    assign w_f     = w_slice[3:0];

`ifdef ALU_SEQ_ACCUM_EN
    assign w_a_src = acc ? r_f : a;
`else
    assign w_a_src = a;
`endif

    // Sequencer, slice datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= 4'd0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_pp    <= 1'b0;
            r_gg    <= 1'b0;
            r_eq    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_equal <= 1'b0;
            r_p_n   <= 1'b0;
            r_g_n   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_a     <= w_a_src;
                        r_b     <= b;
                        r_s     <= s;
                        r_m     <= m;
                        r_carry <= cn;
                        r_pp    <= 1'b1;
                        r_gg    <= 1'b0;
                        r_eq    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 3'd4;
                    r_b     <= r_b >> 3'd4;
                    r_carry <= w_cn4;
                    r_eq    <= r_eq & w_aeqb;
                    r_gg    <= w_g | (w_p & r_gg);
                    r_pp    <= w_p & r_pp;
                    for (int k = 0; k < NSLICE; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_f[4*k +: 4] <= w_f;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_cn4;
                        r_equal <= r_eq & w_aeqb;
                        r_p_n   <= ~(w_p & r_pp);
                        r_g_n   <= ~(w_g | (w_p & r_gg));
                    end else begin
                        r_idx   <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign f     = r_f;
    assign cout  = r_cout;
    assign equal = r_equal;
    assign p_n   = r_p_n;
    assign g_n   = r_g_n;

endmodule

// File: tb/tb_alu_74181_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_74181_seq
// Directed-vector bench for alu_74181_seq at WIDTH=16 (four slices).
// Expected values are hand-computed 74181 results.
// -----------------------------------------------------------------------------
module tb_alu_74181_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cn;
    logic        acc;
    logic        busy;
    logic        done;
    logic [15:0] f;
    logic        cout;
    logic        equal;
    logic        p_n;
    logic        g_n;

    int n_checks;
    int n_passed;

    alu_74181_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .m     (m),
        .cn    (cn),
`ifdef ALU_SEQ_ACCUM_EN
        .acc   (acc),
`endif
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout),
        .equal (equal),
        .p_n   (p_n),
        .g_n   (g_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check the busy/done framing; returns at the
    // falling edge inside the done cycle.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tcn);
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; cn = tcn; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk("busy_run", {31'd0, busy}, 32'd1);
                chk("done_early", {31'd0, done}, 32'd0);
            end else begin
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int n_done;
        int first_done;
        n_checks = 0;
        n_passed = 0;
        rst = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
        s = 4'd0; m = 1'b0; cn = 1'b1; acc = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {25'd0, busy, done, cout, equal, p_n, g_n, 1'b0},  32'd0);
        chk("rst_f", {16'd0, f}, 32'd0);
        rst = 1'b0;

        // Add 0x1234 + 0x4321, no carry in
        run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
        chk("add_f", {16'd0, f}, 32'h5555);
        chk("add_cout", {31'd0, cout}, 32'd1);
        chk("add_equal", {31'd0, equal}, 32'd0);
        chk("add_p_n", {31'd0, p_n}, 32'd1);
        chk("add_g_n", {31'd0, g_n}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_hold_f", {16'd0, f}, 32'h5555);

        // Carry ripple across all four slices
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        chk("ripple_f", {16'd0, f}, 32'h0000);
        chk("ripple_cout", {31'd0, cout}, 32'd0);
        chk("ripple_g_n", {31'd0, g_n}, 32'd0);
        chk("ripple_p_n", {31'd0, p_n}, 32'd0);

        // Logic XOR
        run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
        chk("xor_f", {16'd0, f}, 32'h0FF0);
        chk("xor_equal", {31'd0, equal}, 32'd0);
        chk("xor_cout", {31'd0, cout}, 32'd1);

        // A minus B minus 1 with A == B gives all ones
        run_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1);
        chk("sub_f", {16'd0, f}, 32'hFFFF);
        chk("sub_equal", {31'd0, equal}, 32'd1);
        chk("sub_cout", {31'd0, cout}, 32'd1);
        chk("sub_p_n", {31'd0, p_n}, 32'd0);
        chk("sub_g_n", {31'd0, g_n}, 32'd1);
        repeat (2) @(negedge clk);
        chk("hold_equal", {31'd0, equal}, 32'd1);
        chk("hold_f", {16'd0, f}, 32'hFFFF);

        // Start pulsed during RUN is ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0; cn = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0; first_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
        end
        start = 1'b0;
        chk("ignore_n_done", n_done, 32'd1);
        chk("ignore_done_at", first_done, 32'd5);
        chk("ignore_f", {16'd0, f}, 32'h3333);

        // Back-to-back: start re-asserted in the DONE cycle
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0; first_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (k == 5) begin
                chk("b2b_first_f", {16'd0, f}, 32'h0002);
                a = 16'h0100; b = 16'h0200; start = 1'b1;
            end
            if (k == 10) begin
                chk("b2b_second_done", {31'd0, done}, 32'd1);
                chk("b2b_second_f", {16'd0, f}, 32'h0300);
            end
        end
        start = 1'b0;
        chk("b2b_n_done", n_done, 32'd2);
        chk("b2b_first_at", first_done, 32'd5);

        // Reset mid-operation aborts with no done
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {25'd0, busy, done, cout, equal, p_n, g_n, 1'b0}, 32'd0);
        chk("abort_f", {16'd0, f}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("abort_no_done", n_done, 32'd0);

        // Reset and start together: reset wins
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);

        // Normal operation after reset; carry ripples through two slices
        run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        chk("post_rst_f", {16'd0, f}, 32'h0100);
        chk("post_rst_cout", {31'd0, cout}, 32'd1);

`ifdef ALU_SEQ_ACCUM_EN
        acc = 1'b0;
        run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1);
        chk("accum_base_f", {16'd0, f}, 32'h0002);
        acc = 1'b1;
        run_op(16'h7777, 16'h0003, 4'b1001, 1'b0, 1'b1);
        acc = 1'b0;
        chk("accum_f", {16'd0, f}, 32'h0005);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_74181_seq.md
# alu_74181_seq

Parametrised, slice-serial successor to the dual-74181 datapath: one 74181-equivalent 4-bit slice is reused over `WIDTH/4` cycles to evaluate a `WIDTH`-bit operation. Carry and group lookahead terms are registered between slices, and a start/busy/done handshake frames each operation. It sits behind the SPI register file, in place of the fixed 8-bit cascade. Config registers drive the operands and control; F and the flags return as status registers.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Must be a multiple of 4 and ≥4; any other value is an elaboration error. `NSLICE = WIDTH/4`.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `start`  in  1  — request; sampled only when not busy.
- `a`, `b`  in  WIDTH  — operands; latched on an accepted start.
- `s`  in  4  — 74181 function select; latched on start.
- `m`  in  1  — 1 = logic mode, 0 = arithmetic; latched on start.
- `cn`  in  1  — carry in, 74181 active-high-data convention (1 = no carry); latched on start.
- `acc`  in  1  — only with `ALU_SEQ_ACCUM_EN`. When 1, operand A is taken from the previous F.
- `busy`  out  1  — high while slices are being evaluated.
- `done`  out  1  — one-cycle pulse; the results below are valid from this cycle.
- `f`  out  WIDTH  — result.
- `cout`  out  1  — final slice cn4 (active-low carry, 74181 convention).
- `equal`  out  1  — AND of all slice A=B outputs, i.e. `f` is all ones.
- `p_n`, `g_n`  out  1  — word-level propagate/generate, active-low.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + `start` → RUN:
  - latch a, b, s, m, cn;
  - slice index := 0;
  - carry reg := cn;
  - running propagate pp := 1; running generate gg := 0.
- RUN, each cycle, on slice `i` (LSB slice first):
  - evaluate the full 74181 truth table on `a[4i+3:4i]`, `b[4i+3:4i]`, latched s/m and the carry reg;
  - write the 4-bit result into `f[4i+3:4i]`;
  - carry reg := slice cn4;
  - equal accumulator &= slice A=B;
  - with slice active-high terms p_i = ~P̅, g_i = ~G̅: gg := g_i | (p_i & gg), pp := p_i & pp.
  - In logic mode (m=1) the carry reg and slice outputs are still updated; only f is defined by the function.
- RUN with i = NSLICE-1 → DONE:
  - register `cout`, `equal`, `p_n = ~pp`, `g_n = ~gg`;
  - raise `done`.
- DONE → IDLE the next cycle unless `start` is high; a start in DONE is accepted (back-to-back operation).
- `start` while in RUN is ignored; it is not queued.
- Outputs hold their last values until the next accepted start.
- `f` bits of not-yet-processed slices keep their previous values during RUN; only `done` qualifies `f`.
- Slice index counter width is `max(1, $clog2(NSLICE))`. It never exceeds NSLICE-1.

## Timing
- Reset values: `busy`=0, `done`=0, `f`=0, `cout`=0, `equal`=0, `p_n`=0, `g_n`=0; state IDLE; internal registers 0.
- Let `start` be sampled high at edge E0:
  - `busy` is high for cycles E0+1 … E0+NSLICE;
  - `done` is high during cycle E0+NSLICE+1, with `busy` low.
- Latency: NSLICE+1 cycles from accepted start to `done`.
- Throughput: one operation per NSLICE+1 cycles, with start held or re-asserted in the DONE cycle.
- `rst` asserted in any state, including mid-RUN:
  - next cycle is IDLE with all outputs at reset values;
  - no `done` is produced for the aborted operation.
- `rst` and `start` high in the same cycle: reset wins and start is dropped.

## Configuration
- `ALU_SEQ_ACCUM_EN` defined:
  - the `acc` port exists;
  - on an accepted start with `acc`=1, the A operand latched is the current `f`; `a` is ignored.
- Not defined:
  - no `acc` port and no mux;
  - A always comes from `a`;
  - otherwise identical behaviour and timing.

## Test plan
- Add, WIDTH=16: s=1001, m=0, cn=1, a=0x1234, b=0x4321, start at E0 → `busy` high E0+1..E0+4; `done` at E0+5; f=0x5555, cout=1.
- Carry ripple across all slices: same mode, a=0xFFFF, b=0x0001 → f=0x0000, cout=0, g_n=0.
- Logic and equal:
  - m=1, s=0110, a=0xF0F0, b=0xFF00 → f=0x0FF0, equal=0.
  - Then m=0, s=0110, cn=1, a=b=0x3C3C → f=0xFFFF, equal=1.
- Handshake:
  - start pulsed again at E0+2 → ignored; exactly one `done`, at E0+5.
  - start held in the DONE cycle → second op accepted; its `done` arrives 5 cycles later.
- Reset mid-operation: `rst` at E0+2 → at E0+3 all outputs 0, busy=0; no `done` in the following 10 cycles.
- With `ALU_SEQ_ACCUM_EN`:
  - add a=1, b=1 → f=2;
  - then acc=1, b=3, a=0x7777 → f=5.
